// File: rtl/nz_pingpong_buf_pkg.sv
// Shared definitions for the sparse-dense multiply datapath: default widths
// of the compressed nonzero stream and the per-bank state enum used by the
// ping-pong row buffer, the sparse loader and the MAC controller.
package nz_pingpong_buf_pkg;

  localparam int unsigned NZ_DATA_W = 16;  // nonzero value width
  localparam int unsigned NZ_COL_W  = 8;   // column index width
  localparam int unsigned NZ_DEPTH  = 16;  // max entries per bank (power of two)

  // Write-side bank cycles FILL -> FULL, read-side bank cycles DRAIN -> FREE.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2,
    FREE  = 2'd3
  } bank_state_t;

endpackage

// File: rtl/nz_bank.sv
// One bank of the nonzero row buffer: DEPTH x {value, col, last} storage with
// a write port addressed by the bank's own fill count and a combinational
// read port.
//   clk, reset      : clock, asynchronous active-low reset (clears count)
//   wr_en           : store {wr_value, wr_col, wr_last} at index count
//   clr             : restart filling (count to 0)
//   rd_addr         : read index; rd_value/rd_col/rd_last show that entry
//   count           : number of entries stored in the current row
module nz_bank #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COL_W  = 8,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_value,
  input  logic [COL_W-1:0]  wr_col,
  input  logic              wr_last,
  input  logic              clr,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_value,
  output logic [COL_W-1:0]  rd_col,
  output logic              rd_last,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned ENT_W = DATA_W + COL_W + 1;

  // Contents need no reset: they are only visible while the bank is DRAIN.
  logic [ENT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[count[PTR_W-1:0]] <= {wr_value, wr_col, wr_last};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (wr_en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign {rd_value, rd_col, rd_last} = mem[rd_addr];

endmodule

// File: rtl/nz_pingpong_buf.sv
// Double-buffered nonzero row buffer. One bank is filled with the compressed
// nonzero stream of a sparse row while the other is drained to the MAC array;
// the banks exchange on a one-cycle swap pulse once the write bank holds a
// complete row and the read bank has been fully drained.
//   clk, reset                         : clock, asynchronous active-low reset
//   in_valid/in_ready                  : upstream handshake
//   in_value/in_col/in_last            : nonzero entry, last marks row end
//   out_valid/out_ready                : downstream handshake
//   out_value/out_col/out_last         : entry at read pointer (0 when idle)
//   swap                               : banks exchange at end of this cycle
//   wr_bank/rd_bank                    : bank currently written / read
//   overflow                           : sticky, a row exceeded DEPTH entries
module nz_pingpong_buf
  import nz_pingpong_buf_pkg::*;
#(
  parameter int unsigned DATA_W = NZ_DATA_W,
  parameter int unsigned COL_W  = NZ_COL_W,
  parameter int unsigned DEPTH  = NZ_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_value,
  input  logic [COL_W-1:0]  in_col,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_value,
  output logic [COL_W-1:0]  out_col,
  output logic              out_last,
  output logic              swap,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  bank_state_t st0, st1, st0_nxt, st1_nxt;
  bank_state_t wr_st, rd_st, wr_st_nxt, rd_st_nxt;

  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt0, cnt1, wr_cnt;
  logic [DATA_W-1:0] value0, value1, raw_value;
  logic [COL_W-1:0]  col0, col1, raw_col;
  logic              last0, last1, raw_last;
  logic              accept, rd_hs, at_limit, stored_last;

  // Role view of the two physical banks.
  assign wr_st   = wr_bank ? st1 : st0;
  assign rd_st   = wr_bank ? st0 : st1;
  assign rd_bank = ~wr_bank;

  assign in_ready  = (wr_st == FILL);
  assign out_valid = (rd_st == DRAIN);
  assign swap      = (wr_st == FULL) && (rd_st == FREE);

  assign accept = in_valid && in_ready;
  assign rd_hs  = out_valid && out_ready;

  assign wr_cnt      = wr_bank ? cnt1 : cnt0;
  assign at_limit    = (wr_cnt == CNT_W'(DEPTH - 1));
  // The DEPTH-th entry always closes the row, marked last whether or not
  // upstream said so.
  assign stored_last = in_last | at_limit;

  assign raw_value = wr_bank ? value0 : value1;
  assign raw_col   = wr_bank ? col0   : col1;
  assign raw_last  = wr_bank ? last0  : last1;

  assign out_value = out_valid ? raw_value : '0;
  assign out_col   = out_valid ? raw_col   : '0;
  assign out_last  = out_valid ? raw_last  : 1'b0;

  // Next state computed per role, then mapped back onto physical banks.
  always_comb begin
    wr_st_nxt = wr_st;
    rd_st_nxt = rd_st;
    if (swap) begin
      wr_st_nxt = DRAIN;
      rd_st_nxt = FILL;
    end else begin
      if (accept && stored_last) wr_st_nxt = FULL;
      if (rd_hs && raw_last)     rd_st_nxt = FREE;
    end
    st0_nxt = wr_bank ? rd_st_nxt : wr_st_nxt;
    st1_nxt = wr_bank ? wr_st_nxt : rd_st_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st0      <= FILL;
      st1      <= FREE;
      wr_bank  <= 1'b0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      st0 <= st0_nxt;
      st1 <= st1_nxt;
      if (swap) begin
        wr_bank <= ~wr_bank;
        rd_ptr  <= '0;
      end else if (rd_hs) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (accept && at_limit && !in_last) begin
        overflow <= 1'b1;
      end
    end
  end

  nz_bank #(
    .DATA_W (DATA_W),
    .COL_W  (COL_W),
    .DEPTH  (DEPTH)
  ) u_bank0 (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (accept && !wr_bank),
    .wr_value (in_value),
    .wr_col   (in_col),
    .wr_last  (stored_last),
    .clr      (swap && wr_bank),
    .rd_addr  (rd_ptr),
    .rd_value (value0),
    .rd_col   (col0),
    .rd_last  (last0),
    .count    (cnt0)
  );

  nz_bank #(
    .DATA_W (DATA_W),
    .COL_W  (COL_W),
    .DEPTH  (DEPTH)
  ) u_bank1 (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (accept && wr_bank),
    .wr_value (in_value),
    .wr_col   (in_col),
    .wr_last  (stored_last),
    .clr      (swap && !wr_bank),
    .rd_addr  (rd_ptr),
    .rd_value (value1),
    .rd_col   (col1),
    .rd_last  (last1),
    .count    (cnt1)
  );

endmodule

// File: tb/tb_nz_pingpong_buf.sv
// Directed bench for nz_pingpong_buf (DATA_W=16, COL_W=8, DEPTH=16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_nz_pingpong_buf;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_value = '0;
  logic [7:0]  in_col = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_value;
  logic [7:0]  out_col;
  logic        out_last;
  logic        swap;
  logic        wr_bank;
  logic        rd_bank;
  logic        overflow;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  nz_pingpong_buf #(
    .DATA_W (16),
    .COL_W  (8),
    .DEPTH  (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_col    (in_col),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_col   (out_col),
    .out_last  (out_last),
    .swap      (swap),
    .wr_bank   (wr_bank),
    .rd_bank   (rd_bank),
    .overflow  (overflow)
  );

  // Drive one entry until accepted (bounded); ok reports acceptance.
  task automatic send(input logic [15:0] v, input logic [7:0] c, input logic l, output bit ok);
    int n = 0;
    in_valid = 1'b1; in_value = v; in_col = c; in_last = l;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({in_ready, out_valid, wr_bank, rd_bank, swap, overflow} !== 6'b100100) begin
      bad++;
      $display("FAIL reset_hold got=%b want=100100", {in_ready, out_valid, wr_bank, rd_bank, swap, overflow});
    end
    total++;
    if ({out_value, out_col, out_last} !== 25'd0) begin
      bad++;
      $display("FAIL reset_outs got=%h want=0", {out_value, out_col, out_last});
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, wr_bank, rd_bank, swap, overflow} !== 6'b100100) begin
      bad++;
      $display("FAIL reset_release got=%b want=100100", {in_ready, out_valid, wr_bank, rd_bank, swap, overflow});
    end
  endtask

  task automatic test_single_row();
    bit ok, okall;
    okall = 1'b1;
    out_ready = 1'b1;
    send(16'd10, 8'd1, 1'b0, ok); okall &= ok;
    send(16'd20, 8'd4, 1'b0, ok); okall &= ok;
    send(16'd30, 8'd7, 1'b1, ok); okall &= ok;
    total++;
    if (!okall) begin bad++; $display("FAIL single_accept got=0 want=1"); end
    total++;
    if ({swap, in_ready, out_valid, wr_bank} !== 4'b1000) begin
      bad++;
      $display("FAIL single_swap got=%b want=1000", {swap, in_ready, out_valid, wr_bank});
    end
    @(negedge clk);
    total++;
    if ({swap, in_ready, out_valid, wr_bank, rd_bank} !== 5'b01110) begin
      bad++;
      $display("FAIL single_after_swap got=%b want=01110", {swap, in_ready, out_valid, wr_bank, rd_bank});
    end
    total++;
    if ({out_value, out_col, out_last} !== {16'd10, 8'd1, 1'b0}) begin
      bad++;
      $display("FAIL single_e0 got=%h want=%h", {out_value, out_col, out_last}, {16'd10, 8'd1, 1'b0});
    end
    @(negedge clk);
    total++;
    if ({out_valid, out_value, out_col, out_last} !== {1'b1, 16'd20, 8'd4, 1'b0}) begin
      bad++;
      $display("FAIL single_e1 got=%h want=%h", {out_valid, out_value, out_col, out_last}, {1'b1, 16'd20, 8'd4, 1'b0});
    end
    @(negedge clk);
    total++;
    if ({out_valid, out_value, out_col, out_last} !== {1'b1, 16'd30, 8'd7, 1'b1}) begin
      bad++;
      $display("FAIL single_e2 got=%h want=%h", {out_valid, out_value, out_col, out_last}, {1'b1, 16'd30, 8'd7, 1'b1});
    end
    @(negedge clk);
    total++;
    if ({out_valid, out_value, out_col, out_last, swap} !== 27'd0) begin
      bad++;
      $display("FAIL single_idle got=%h want=0", {out_valid, out_value, out_col, out_last, swap});
    end
  endtask

  task automatic test_back_to_back();
    bit ok, okall;
    okall = 1'b1;
    pulse_reset();
    send(16'h00A1, 8'd3, 1'b0, ok); okall &= ok;
    send(16'h00A2, 8'd5, 1'b0, ok); okall &= ok;
    send(16'h00A3, 8'd9, 1'b1, ok); okall &= ok;
    send(16'h00B1, 8'd2, 1'b0, ok); okall &= ok;
    send(16'h00B2, 8'd6, 1'b1, ok); okall &= ok;
    total++;
    if (!okall) begin bad++; $display("FAIL b2b_accept got=0 want=1"); end
    total++;
    if ({in_ready, swap, out_valid, wr_bank} !== 4'b0011) begin
      bad++;
      $display("FAIL b2b_stall got=%b want=0011", {in_ready, swap, out_valid, wr_bank});
    end
    total++;
    if ({out_value, out_col, out_last} !== {16'h00A1, 8'd3, 1'b0}) begin
      bad++;
      $display("FAIL b2b_a0_held got=%h want=%h", {out_value, out_col, out_last}, {16'h00A1, 8'd3, 1'b0});
    end
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, swap} !== 2'b00) begin
      bad++;
      $display("FAIL b2b_still_stalled got=%b want=00", {in_ready, swap});
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({out_valid, out_value, out_col, out_last} !== {1'b1, 16'h00A2, 8'd5, 1'b0}) begin
      bad++;
      $display("FAIL b2b_a1 got=%h want=%h", {out_valid, out_value, out_col, out_last}, {1'b1, 16'h00A2, 8'd5, 1'b0});
    end
    @(negedge clk);
    total++;
    if ({out_valid, out_value, out_col, out_last} !== {1'b1, 16'h00A3, 8'd9, 1'b1}) begin
      bad++;
      $display("FAIL b2b_a2 got=%h want=%h", {out_valid, out_value, out_col, out_last}, {1'b1, 16'h00A3, 8'd9, 1'b1});
    end
    @(negedge clk);
    total++;
    if ({out_valid, swap} !== 2'b01) begin
      bad++;
      $display("FAIL b2b_swap got=%b want=01", {out_valid, swap});
    end
    @(negedge clk);
    total++;
    if ({swap, out_valid, wr_bank, rd_bank} !== 4'b0101) begin
      bad++;
      $display("FAIL b2b_banks got=%b want=0101", {swap, out_valid, wr_bank, rd_bank});
    end
    total++;
    if ({out_value, out_col, out_last} !== {16'h00B1, 8'd2, 1'b0}) begin
      bad++;
      $display("FAIL b2b_b0 got=%h want=%h", {out_value, out_col, out_last}, {16'h00B1, 8'd2, 1'b0});
    end
    @(negedge clk);
    total++;
    if ({out_valid, out_value, out_col, out_last} !== {1'b1, 16'h00B2, 8'd6, 1'b1}) begin
      bad++;
      $display("FAIL b2b_b1 got=%h want=%h", {out_valid, out_value, out_col, out_last}, {1'b1, 16'h00B2, 8'd6, 1'b1});
    end
    @(negedge clk);
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL b2b_end got=%b want=01", {out_valid, in_ready});
    end
  endtask

  task automatic test_overflow();
    bit ok, okall;
    okall = 1'b1;
    pulse_reset();
    for (int i = 1; i <= 15; i++) begin
      send(16'(i), 8'(i + 32), 1'b0, ok); okall &= ok;
    end
    total++;
    if ({overflow, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL ovf_before got=%b want=01", {overflow, in_ready});
    end
    send(16'd16, 8'd48, 1'b0, ok); okall &= ok;
    total++;
    if (!okall) begin bad++; $display("FAIL ovf_accept got=0 want=1"); end
    total++;
    if ({overflow, in_ready, swap} !== 3'b101) begin
      bad++;
      $display("FAIL ovf_set got=%b want=101", {overflow, in_ready, swap});
    end
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      total++;
      if ({out_valid, out_value, out_col, out_last} !== {1'b1, 16'(i), 8'(i + 32), (i == 16)}) begin
        bad++;
        $display("FAIL ovf_drain%0d got=%h want=%h", i, {out_valid, out_value, out_col, out_last},
                 {1'b1, 16'(i), 8'(i + 32), (i == 16)});
      end
      @(negedge clk);
    end
    send(16'd5, 8'd2, 1'b1, ok);
    @(negedge clk);
    total++;
    if ({out_valid, out_value, out_col, out_last, overflow} !== {1'b1, 16'd5, 8'd2, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL ovf_next_row got=%h want=%h", {out_valid, out_value, out_col, out_last, overflow},
               {1'b1, 16'd5, 8'd2, 1'b1, 1'b1});
    end
    @(negedge clk);
    total++;
    if ({out_valid, overflow} !== 2'b01) begin
      bad++;
      $display("FAIL ovf_sticky got=%b want=01", {out_valid, overflow});
    end
  endtask

  task automatic test_random();
    int lens[8];
    int sum = 0, r = 0, e = 0, got = 0, swaps = 0, cyc = 0;
    bit pair_bad = 1'b0;
    logic [15:0] cv;
    logic [7:0]  cc;
    logic [24:0] q[$];
    logic [24:0] exp;
    pulse_reset();
    for (int k = 0; k < 8; k++) begin
      lens[k] = $urandom_range(1, 16);
      sum += lens[k];
    end
    cv = 16'($urandom); cc = 8'($urandom);
    while (got < sum && cyc < 4000) begin
      if (r < 8 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1; in_value = cv; in_col = cc; in_last = (e == lens[r] - 1);
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      out_ready = 1'($urandom_range(0, 1));
      if (wr_bank === rd_bank) pair_bad = 1'b1;
      if (swap === 1'b1) swaps++;
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL rand_extra got=%h want=none", {out_value, out_col, out_last});
        end else begin
          exp = q.pop_front();
          if ({out_value, out_col, out_last} !== exp) begin
            bad++;
            $display("FAIL rand_data got=%h want=%h", {out_value, out_col, out_last}, exp);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back({cv, cc, in_last});
        if (in_last) begin r++; e = 0; end else e++;
        cv = 16'($urandom); cc = 8'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    total++;
    if (got != sum || q.size() != 0) begin
      bad++;
      $display("FAIL rand_count got=%0d want=%0d (left %0d)", got, sum, q.size());
    end
    total++;
    if (swaps != 8) begin bad++; $display("FAIL rand_swaps got=%0d want=8", swaps); end
    total++;
    if (pair_bad) begin bad++; $display("FAIL rand_bank_pair got=equal want=complementary"); end
  endtask

  task automatic test_reset_mid_drain();
    bit ok, okall, stale;
    okall = 1'b1;
    stale = 1'b0;
    pulse_reset();
    out_ready = 1'b1;
    send(16'h0041, 8'd1, 1'b0, ok); okall &= ok;
    send(16'h0042, 8'd2, 1'b0, ok); okall &= ok;
    send(16'h0043, 8'd3, 1'b0, ok); okall &= ok;
    send(16'h0044, 8'd4, 1'b1, ok); okall &= ok;
    total++;
    if (!okall) begin bad++; $display("FAIL rst_accept got=0 want=1"); end
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({out_valid, out_value} !== {1'b1, 16'h0042}) begin
      bad++;
      $display("FAIL rst_second got=%h want=%h", {out_valid, out_value}, {1'b1, 16'h0042});
    end
    reset = 1'b0;
    #1;
    total++;
    if ({out_valid, in_ready, wr_bank, rd_bank, swap} !== 5'b01010 || out_value !== 16'd0) begin
      bad++;
      $display("FAIL rst_async got=%b/%h want=01010/0", {out_valid, in_ready, wr_bank, rd_bank, swap}, out_value);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, wr_bank, rd_bank, swap, overflow} !== 6'b100100) begin
      bad++;
      $display("FAIL rst_after got=%b want=100100", {in_ready, out_valid, wr_bank, rd_bank, swap, overflow});
    end
    for (int k = 0; k < 8; k++) begin
      if (out_valid !== 1'b0) stale = 1'b1;
      @(negedge clk);
    end
    total++;
    if (stale) begin bad++; $display("FAIL rst_stale got=valid want=idle"); end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_back_to_back();
    test_overflow();
    test_random();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got=stuck want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nz_pingpong_buf.md
# nz_pingpong_buf

Double-buffered nonzero row buffer for the sparse-dense multiply datapath. It takes the compressed nonzero stream of one sparse row at a time (value, column index, last flag) from the sparse loader and fills one bank with it. Meanwhile the other bank is drained to the MAC array. It owns the complementary write/read bank-select pair and emits the one-cycle swap pulse that advances it.

## Interface
- DATA_W, 16, nonzero value width
- COL_W, 8, column index width
- DEPTH, 16, max entries per bank (power of two, ≥2)

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; clears all state
- in_valid  input  1  upstream entry valid
- in_ready  output  1  entry accepted when in_valid && in_ready
- in_value  input  DATA_W  nonzero value
- in_col  input  COL_W  column index
- in_last  input  1  final nonzero of current row
- out_valid  output  1  read-bank entry available
- out_ready  input  1  downstream accepts when out_valid && out_ready
- out_value  output  DATA_W  value at read pointer
- out_col  output  COL_W  column at read pointer
- out_last  output  1  final entry of drained row
- swap  output  1  one-cycle pulse; banks exchange at the end of this cycle
- wr_bank  output  1  bank currently written
- rd_bank  output  1  bank currently read, always ~wr_bank
- overflow  output  1  sticky: a row exceeded DEPTH entries

## Operation
- Two banks, each with entry storage, a count (log2(DEPTH)+1 bits) and a state: FILL, FULL, DRAIN, FREE.
- Write bank cycles FILL → FULL. Read bank cycles DRAIN → FREE.
- Write: on each accepted entry, store at the count index and increment the count. On an accepted in_last, the write bank goes to FULL.
- Overflow: if the DEPTH-th entry is accepted without in_last, it is stored with last forced to 1. The bank goes to FULL and overflow is set. overflow clears only on reset.
- in_ready = (write bank in FILL).
- Swap condition: write bank FULL and read bank FREE. swap = condition, combinational from registered state.
- At a swap edge, wr_bank and rd_bank toggle. The former write bank becomes the read bank in DRAIN with its read pointer at 0. The former read bank becomes the write bank in FILL with its count at 0.
- Read: out_valid = (read bank in DRAIN). Outputs show the entry at the read pointer. out_last = 1 on entry count−1 (or its stored forced-last).
- Each read handshake increments the read pointer. The handshake on the last entry moves the read bank to FREE.
- While out_valid=0, out_value, out_col and out_last are driven to 0.
- Rows always contain ≥1 entry. Zero-nonzero rows are never sent upstream.

## Timing
- Reset values: wr_bank=0, rd_bank=1, both counts and pointers 0, write bank in FILL, read bank in FREE. Outputs: in_ready=1, out_valid=0, swap=0, overflow=0.
- Reset asserted mid-row or mid-drain discards all contents immediately (asynchronous). Operation resumes from the reset state on the first edge after deassertion.
- in_last accepted at edge N: FULL from N, in_ready=0 in cycle N..N+1. If the read bank is FREE, swap=1 in cycle N..N+1. At edge N+1 the banks toggle, out_valid=1 and in_ready=1.
- One mandatory bubble cycle per row on the input side.
- Last read handshake at edge M sets FREE at M. A pending FULL write bank swaps at edge M+1, so swap=1 in cycle M..M+1.
- Read is zero-latency from the storage array. Entry order within a row is preserved exactly.
- Write and read on the same cycle always target opposite banks, so there is no hazard.

## Structure
- Shared package: DATA_W/COL_W/DEPTH defaults and the bank-state enum {FILL, FULL, DRAIN, FREE}. Shared with the loader and the MAC controller.
- Sub-module nz_bank, instantiated twice:
  - storage array of {value, col, last}
  - write port, combinational read port
  - count register
- Top level holds the bank-select pair, the two state registers, the read pointer, the swap logic and overflow.

## Test plan
- Reset → in_ready=1, out_valid=0, wr_bank=0, rd_bank=1, swap=0, overflow=0.
- Row (10,c1),(20,c4),(30,c7,last) with out_ready=1 → swap high exactly one cycle after the last accept. Then wr_bank=1, rd_bank=0. Outputs stream 10/1, 20/4, 30/7 on consecutive cycles, with out_last only on 30.
- Row A (3 entries) then row B (2 entries), out_ready=0 → row B fills bank 1. in_ready stays 0 after B's last. Raise out_ready: A drains, then swap one cycle after A's last handshake, then B streams.
- DEPTH=16 entries (values 1..16), no in_last → 16th output carries out_last=1 and overflow=1. The next row (5,c2,last) drains normally and overflow stays 1.
- Random out_ready toggling over 8 rows of random lengths 1..16 → output sequence equals input sequence. swap count is 8 and wr_bank always equals ~rd_bank.
- Assert reset while the second entry of a 4-entry row drains → out_valid=0 immediately. After release, all reset values hold and no stale entry is ever output.
